bus_initiator: RTL
==================

Name: bus_initiator

Overview:
- Initiator (master) end of the AW/W/AR/R word-bus that the systolic-array controller responds on.
- Turns single-word host requests into channel handshakes: scratchpad reads/writes, matmul address setup writes (0xF0000/0xF0001/0xF0003) and matmul start writes (AWADDR[23:20]=1).
- Returns read data or write completion to the requester on a valid/ready response port.
- Sits between the testbench or host command source and the controller.

Parameters:
- TIMEOUT_CYCLES, 1024: maximum cycles spent waiting in any one channel-wait state before abort; used only with the optional feature.
- CNT_W, 16: width of the completed-transaction counters.

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when high with req_valid.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  word_t  request address.
- req_wdata  in  word_t  write data; ignored for reads.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester takes the response.
- rsp_write  out  1  response belongs to a write.
- rsp_rdata  out  word_t  read data; 0 for writes.
- rsp_err  out  1  transaction aborted by timeout.
- AWVALID  out  1  write address valid.
- AWADDR  out  word_t  write address.
- AWREADY  in  1  write address accepted.
- WDVALID  out  1  write data valid.
- WDATA  out  word_t  write data.
- WDREADY  in  1  write data accepted.
- ARVALID  out  1  read address valid.
- ARADDR  out  word_t  read address.
- ARREADY  in  1  read address accepted.
- RDREADY  out  1  initiator ready for read data.
- RDVALID  in  1  read data valid.
- RDATA  in  word_t  read data.
- busy  out  1  high in any state other than IDLE.
- wr_count, rd_count  out  CNT_W  completed writes and reads; wrap modulo 2^CNT_W.

Behaviour:
- Reset (asynchronous, any state): state IDLE. All outputs 0, except req_ready=1. This includes AWVALID, WDVALID, ARVALID, RDREADY, rsp_*, counters and the address/data registers. Any transaction in flight is dropped without a response.
- All bus and response outputs are registered. req_ready is a decode of state: high only in IDLE.
- States: IDLE, AW, W, AR, R, RESP.
- IDLE:
  - On req_valid, latch addr, wdata and write.
  - Write: go to AW. AWVALID=1 and AWADDR=addr are visible the next cycle.
  - Read: go to AR. ARVALID=1 and ARADDR=addr are visible the next cycle.
- AW: hold AWVALID and AWADDR stable until AWREADY is sampled high. Next cycle: AWVALID=0, WDVALID=1, WDATA=wdata, state W. AWADDR holds its value through W (the responder reads AWADDR while in its write state).
- W: hold WDVALID until WDREADY is sampled high. Next cycle: WDVALID=0, state RESP with rsp_valid=1, rsp_write=1, rsp_rdata=0, rsp_err=0. wr_count increments on the same edge.
- AR: hold ARVALID and ARADDR until ARREADY is sampled high. Next cycle: ARVALID=0, RDREADY=1, state R. ARADDR holds through R.
- R: hold RDREADY until RDVALID is sampled high. On that edge, capture RDATA into rsp_rdata. Next cycle: RDREADY=0, state RESP with rsp_write=0. rd_count increments.
- RESP: hold rsp_* until rsp_ready is sampled high. Next cycle: rsp_valid=0, state IDLE.
- Minimum cost per transaction:
  - Write: 4 cycles with zero-wait responder (accept, AW, W, RESP).
  - Read: 4 cycles (accept, AR, R, RESP).
- Never more than one outstanding transaction. AWVALID, WDVALID and ARVALID are mutually exclusive. A READY input asserted while the matching VALID is low is ignored.
- AWREADY/ARREADY high in the same cycle that VALID first rises counts as the handshake.
- Counter wrap: 0xFFFF + 1 = 0x0000 with CNT_W=16.

Optional Feature:
- Macro: BUS_INITIATOR_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to AW, W, AR or R and increments each cycle the handshake is not seen.
  - When it reaches TIMEOUT_CYCLES-1 with no handshake, the active VALID/RDREADY drops the next cycle and the block goes to RESP with rsp_err=1 and rsp_rdata=0. rsp_write reflects the request type.
  - Counters do not increment on an aborted transaction.
  - A handshake in the same cycle as the limit is reached completes normally.
- Undefined: waits are unbounded, rsp_err is tied 0 and the counter logic is absent.

Test Plan:
- Reset mid-write: assert n_rst low while AWVALID=1 -> AWVALID, WDVALID, busy and wr_count drop to 0 immediately; req_ready=1 after release.
- Write addr 0x00000010, data 0xDEADBEEF, AWREADY high for 1 cycle after 2 waits, WDREADY 1 cycle later -> AWADDR stable 0x10 for 3 cycles; WDATA=0xDEADBEEF; rsp_valid, rsp_write=1, rsp_err=0; wr_count=1.
- Read addr 0x00000020, ARREADY immediate, RDVALID with RDATA=0x12345678 after 3 cycles -> rsp_rdata=0x12345678, rsp_write=0, rd_count=1.
- Setup and start sequence: writes to 0x000F0000, 0x000F0001, 0x000F0003, then 0x00100000, each with a zero-wait responder -> four responses in order; wr_count=4; no overlapping VALIDs.
- Backpressure: rsp_ready low for 5 cycles -> rsp_* stable, req_ready=0 throughout; a new req_valid is not accepted until the cycle after rsp_ready.
- BUS_INITIATOR_TIMEOUT_EN with TIMEOUT_CYCLES=8, ARREADY never asserted -> ARVALID drops after 8 cycles; rsp_err=1, rsp_rdata=0, rd_count unchanged.

Source files
------------

// File: rtl/bus_initiator_if.sv
// Host request/response port plus the AW/W/AR/R word bus between the
// initiator (master) and the systolic-array controller (slave side).
interface bus_initiator_if #(
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [DATA_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_write;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              AWVALID;
  logic [DATA_W-1:0] AWADDR;
  logic              AWREADY;
  logic              WDVALID;
  logic [DATA_W-1:0] WDATA;
  logic              WDREADY;
  logic              ARVALID;
  logic [DATA_W-1:0] ARADDR;
  logic              ARREADY;
  logic              RDREADY;
  logic              RDVALID;
  logic [DATA_W-1:0] RDATA;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  AWREADY, WDREADY, ARREADY, RDVALID, RDATA,
    output req_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err,
    output AWVALID, AWADDR, WDVALID, WDATA, ARVALID, ARADDR, RDREADY
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output AWREADY, WDREADY, ARREADY, RDVALID, RDATA,
    input  req_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err,
    input  AWVALID, AWADDR, WDVALID, WDATA, ARVALID, ARADDR, RDREADY
  );
endinterface

// File: rtl/bus_initiator.sv
// Single-outstanding bus initiator: one host request -> AW/W or AR/R handshakes -> one response.
// Optional per-channel wait timeout enabled by defining BUS_INITIATOR_TIMEOUT_EN.
module bus_initiator #(
  parameter int DATA_W         = 32,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             n_rst,
  bus_initiator_if.master  bus,
  output logic             busy,
  output logic [CNT_W-1:0] wr_count,
  output logic [CNT_W-1:0] rd_count
);
  typedef logic [DATA_W-1:0] word_t;
  typedef enum logic [2:0] {IDLE, AW, W, AR, R, RESP} state_e;

  state_e            state_q, state_d;
  logic              awvalid_q, awvalid_d;
  logic              wdvalid_q, wdvalid_d;
  logic              arvalid_q, arvalid_d;
  logic              rdready_q, rdready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_write_q, rsp_write_d;
  word_t             awaddr_q, awaddr_d;
  word_t             araddr_q, araddr_d;
  word_t             wdata_q, wdata_d;
  word_t             wbuf_q, wbuf_d;
  word_t             rsp_rdata_q, rsp_rdata_d;
  logic [CNT_W-1:0]  wr_count_q, wr_count_d;
  logic [CNT_W-1:0]  rd_count_q, rd_count_d;

`ifdef BUS_INITIATOR_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic          write_q, write_d;
  logic          rsp_err_q, rsp_err_d;
  logic [TW-1:0] wait_q, wait_d;
  logic          in_wait;
`endif

  always_comb begin
    state_d     = state_q;
    awvalid_d   = awvalid_q;
    wdvalid_d   = wdvalid_q;
    arvalid_d   = arvalid_q;
    rdready_d   = rdready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    awaddr_d    = awaddr_q;
    araddr_d    = araddr_q;
    wdata_d     = wdata_q;
    wbuf_d      = wbuf_q;
    rsp_rdata_d = rsp_rdata_q;
    wr_count_d  = wr_count_q;
    rd_count_d  = rd_count_q;
`ifdef BUS_INITIATOR_TIMEOUT_EN
    write_d     = write_q;
    rsp_err_d   = rsp_err_q;
    wait_d      = '0;
    in_wait     = (state_q == AW) || (state_q == W) || (state_q == AR) || (state_q == R);
`endif

    unique case (state_q)
      IDLE: if (bus.req_valid) begin
        wbuf_d = bus.req_wdata;
`ifdef BUS_INITIATOR_TIMEOUT_EN
        write_d = bus.req_write;
`endif
        if (bus.req_write) begin
          awvalid_d = 1'b1;
          awaddr_d  = bus.req_addr;
          state_d   = AW;
        end else begin
          arvalid_d = 1'b1;
          araddr_d  = bus.req_addr;
          state_d   = AR;
        end
      end
      AW: if (bus.AWREADY) begin
        awvalid_d = 1'b0;
        wdvalid_d = 1'b1;
        wdata_d   = wbuf_q;
        state_d   = W;
      end
      W: if (bus.WDREADY) begin
        wdvalid_d   = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_write_d = 1'b1;
        rsp_rdata_d = '0;
        wr_count_d  = wr_count_q + CNT_W'(1);
`ifdef BUS_INITIATOR_TIMEOUT_EN
        rsp_err_d   = 1'b0;
`endif
        state_d     = RESP;
      end
      AR: if (bus.ARREADY) begin
        arvalid_d = 1'b0;
        rdready_d = 1'b1;
        state_d   = R;
      end
      R: if (bus.RDVALID) begin
        rdready_d   = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_write_d = 1'b0;
        rsp_rdata_d = bus.RDATA;
        rd_count_d  = rd_count_q + CNT_W'(1);
`ifdef BUS_INITIATOR_TIMEOUT_EN
        rsp_err_d   = 1'b0;
`endif
        state_d     = RESP;
      end
      RESP: if (bus.rsp_ready) begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

`ifdef BUS_INITIATOR_TIMEOUT_EN
    // Staying in a wait state means no handshake this cycle; a handshake on the limit cycle wins.
    if (in_wait && state_d == state_q) begin
      if (wait_q == TW'(TIMEOUT_CYCLES - 1)) begin
        awvalid_d   = 1'b0;
        wdvalid_d   = 1'b0;
        arvalid_d   = 1'b0;
        rdready_d   = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_write_d = write_q;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b1;
        state_d     = RESP;
      end else begin
        wait_d = wait_q + TW'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      awvalid_q   <= 1'b0;
      wdvalid_q   <= 1'b0;
      arvalid_q   <= 1'b0;
      rdready_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= '0;
      wbuf_q      <= '0;
      rsp_rdata_q <= '0;
      wr_count_q  <= '0;
      rd_count_q  <= '0;
`ifdef BUS_INITIATOR_TIMEOUT_EN
      write_q     <= 1'b0;
      rsp_err_q   <= 1'b0;
      wait_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      awvalid_q   <= awvalid_d;
      wdvalid_q   <= wdvalid_d;
      arvalid_q   <= arvalid_d;
      rdready_q   <= rdready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      awaddr_q    <= awaddr_d;
      araddr_q    <= araddr_d;
      wdata_q     <= wdata_d;
      wbuf_q      <= wbuf_d;
      rsp_rdata_q <= rsp_rdata_d;
      wr_count_q  <= wr_count_d;
      rd_count_q  <= rd_count_d;
`ifdef BUS_INITIATOR_TIMEOUT_EN
      write_q     <= write_d;
      rsp_err_q   <= rsp_err_d;
      wait_q      <= wait_d;
`endif
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign bus.AWVALID   = awvalid_q;
  assign bus.AWADDR    = awaddr_q;
  assign bus.WDVALID   = wdvalid_q;
  assign bus.WDATA     = wdata_q;
  assign bus.ARVALID   = arvalid_q;
  assign bus.ARADDR    = araddr_q;
  assign bus.RDREADY   = rdready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_write = rsp_write_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign wr_count      = wr_count_q;
  assign rd_count      = rd_count_q;
`ifdef BUS_INITIATOR_TIMEOUT_EN
  assign bus.rsp_err   = rsp_err_q;
`else
  assign bus.rsp_err   = 1'b0;
`endif
endmodule
